// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM state type and default widths for the memory-access stage
package mem_stage_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 3;
endpackage

// File: rtl/mem_stage_ram.sv
// mem_stage_ram: DEPTH x DATA_W data memory, synchronous write, combinational read, out-of-range gated
module mem_stage_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    assign in_range = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
    assign idx      = addr[IDX_W-1:0];
    assign rdata    = in_range ? mem[idx] : '0;
    always_ff @(posedge clock) begin
        if (we && in_range) mem[idx] <= wdata;
    end
endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: memory-access stage with LATENCY-cycle memory, stall handshake and MEM/WB register; MEM_STAGE_RANGE_CHECK_EN adds out_fault
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int REG_W   = REG_W_DEF,
    parameter int LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              zero,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    input  logic [REG_W-1:0]  reg_dst,
    input  logic [DATA_W-1:0] branch_target,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [REG_W-1:0]  out_reg_dst,
    output logic              out_reg_write,
`ifdef MEM_STAGE_RANGE_CHECK_EN
    output logic              out_fault,
`endif
    output logic              pc_src,
    output logic [DATA_W-1:0] out_branch_target
);
    localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_op, commit, store;
    logic [DATA_W-1:0] rdata;
    logic              valid_q, reg_write_q, pc_src_q;
    logic [DATA_W-1:0] mem_data_q, alu_q, target_q;
    logic [REG_W-1:0]  dst_q;
    assign mem_op = in_valid & (mem_read | mem_write);
    assign store  = commit & in_valid & mem_write;
    // Reset gates stall and commit so an aborted access neither stalls EX nor writes memory
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        commit  = 1'b0;
        if (state_q == IDLE) begin
            if (mem_op && LATENCY > 1) begin
                stall   = reset_n;
                cnt_d   = CNT_W'(LATENCY - 1);
                state_d = BUSY;
            end else begin
                commit = in_valid & reset_n;
            end
        end else begin
            stall   = reset_n & (cnt_q > CNT_W'(1));
            commit  = reset_n & (cnt_q == CNT_W'(1));
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = commit ? IDLE : BUSY;
        end
    end
    mem_stage_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .we    (store),
        .addr  (alu_result[ADDR_W-1:0]),
        .wdata (write_data),
        .rdata (rdata)
    );
`ifdef MEM_STAGE_RANGE_CHECK_EN
    logic fault_q;
    logic in_range;
    assign in_range  = {1'b0, alu_result[ADDR_W-1:0]} < (ADDR_W+1)'(DEPTH);
    assign out_fault = fault_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) fault_q <= 1'b0;
        else          fault_q <= commit & mem_op & ~in_range;
    end
`endif
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            mem_data_q  <= '0;
            alu_q       <= '0;
            target_q    <= '0;
            dst_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= commit;
            reg_write_q <= commit & reg_write;
            pc_src_q    <= commit & branch & zero;
            if (commit) begin
                mem_data_q <= mem_write ? write_data : rdata;
                alu_q      <= alu_result;
                target_q   <= branch_target;
                dst_q      <= reg_dst;
            end
        end
    end
    assign out_valid         = valid_q;
    assign out_reg_write     = reg_write_q;
    assign pc_src            = pc_src_q;
    assign out_mem_data      = mem_data_q;
    assign out_alu_result    = alu_q;
    assign out_branch_target = target_q;
    assign out_reg_dst       = dst_q;
endmodule

// File: tb/tb_mem_stage_pipe.sv
// tb_mem_stage_pipe: directed checks on a single-cycle/16-word instance (a) and a 3-cycle/256-word instance (b)
module tb_mem_stage_pipe;
    typedef struct packed {
        logic        in_valid;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        zero;
        logic        reg_write;
        logic [15:0] alu_result;
        logic [15:0] write_data;
        logic [15:0] branch_target;
        logic [2:0]  reg_dst;
    } in_t;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    in_t a_in = '0;
    in_t b_in = '0;
    logic        a_stall, a_valid, a_reg_write, a_pc_src;
    logic [15:0] a_mem_data, a_alu, a_target;
    logic [2:0]  a_dst;
    logic        b_stall, b_valid, b_reg_write, b_pc_src;
    logic [15:0] b_mem_data, b_alu, b_target;
    logic [2:0]  b_dst;
`ifdef MEM_STAGE_RANGE_CHECK_EN
    logic a_fault, b_fault;
`endif
    int n_checks = 0;
    int n_fail = 0;
    int st;
    logic pv;
    always #5 clock = ~clock;
    mem_stage_pipe #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .REG_W(3), .LATENCY(1)) u_a (
        .clock(clock), .reset_n(reset_n), .in_valid(a_in.in_valid), .mem_read(a_in.mem_read),
        .mem_write(a_in.mem_write), .branch(a_in.branch), .zero(a_in.zero), .reg_write(a_in.reg_write),
        .alu_result(a_in.alu_result), .write_data(a_in.write_data), .reg_dst(a_in.reg_dst),
        .branch_target(a_in.branch_target), .stall(a_stall), .out_valid(a_valid),
        .out_mem_data(a_mem_data), .out_alu_result(a_alu), .out_reg_dst(a_dst),
        .out_reg_write(a_reg_write),
`ifdef MEM_STAGE_RANGE_CHECK_EN
        .out_fault(a_fault),
`endif
        .pc_src(a_pc_src), .out_branch_target(a_target)
    );
    mem_stage_pipe #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .REG_W(3), .LATENCY(3)) u_b (
        .clock(clock), .reset_n(reset_n), .in_valid(b_in.in_valid), .mem_read(b_in.mem_read),
        .mem_write(b_in.mem_write), .branch(b_in.branch), .zero(b_in.zero), .reg_write(b_in.reg_write),
        .alu_result(b_in.alu_result), .write_data(b_in.write_data), .reg_dst(b_in.reg_dst),
        .branch_target(b_in.branch_target), .stall(b_stall), .out_valid(b_valid),
        .out_mem_data(b_mem_data), .out_alu_result(b_alu), .out_reg_dst(b_dst),
        .out_reg_write(b_reg_write),
`ifdef MEM_STAGE_RANGE_CHECK_EN
        .out_fault(b_fault),
`endif
        .pc_src(b_pc_src), .out_branch_target(b_target)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Presents one instruction at a negedge, holds it through any stall, returns at the negedge after commit
    task automatic op(input bit sel, input logic rd, wr, br, z, rw,
                      input logic [15:0] alu, wd, tgt, input logic [2:0] dst,
                      output int stalls, output logic pre_valid);
        in_t v;
        v = '{1'b1, rd, wr, br, z, rw, alu, wd, tgt, dst};
        if (sel) b_in = v;
        else     a_in = v;
        stalls = 0;
        #1;
        while ((sel ? b_stall : a_stall) && stalls < 20) begin
            stalls++;
            @(negedge clock);
            #1;
        end
        pre_valid = sel ? b_valid : a_valid;
        @(negedge clock);
        if (sel) b_in = '0;
        else     a_in = '0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clock);
        check("rst a_valid", 32'(a_valid), 0);
        check("rst a_mem_data", 32'(a_mem_data), 0);
        check("rst b_stall", 32'(b_stall), 0);
        check("rst b_pc_src", 32'(b_pc_src), 0);
        reset_n = 1'b1;
        op(0, 0, 1, 0, 0, 0, 16'h0005, 16'h1234, 16'h0000, 3'd0, st, pv);
        check("a st5 stalls", 32'(st), 0);
        check("a st5 valid", 32'(a_valid), 1);
        check("a st5 data", 32'(a_mem_data), 32'h1234);
        check("a st5 reg_write", 32'(a_reg_write), 0);
        op(0, 1, 0, 0, 0, 1, 16'h0005, 16'h0000, 16'h0000, 3'd2, st, pv);
        check("a ld5 stalls", 32'(st), 0);
        check("a ld5 valid", 32'(a_valid), 1);
        check("a ld5 data", 32'(a_mem_data), 32'h1234);
        check("a ld5 dst", 32'(a_dst), 2);
        @(negedge clock);
        check("a bubble valid", 32'(a_valid), 0);
        check("a bubble hold", 32'(a_mem_data), 32'h1234);
        check("a bubble reg_write", 32'(a_reg_write), 0);
        op(0, 0, 1, 0, 0, 0, 16'h0004, 16'h0101, 16'h0000, 3'd0, st, pv);
        op(0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0040, 3'd0, st, pv);
        check("a br taken pc_src", 32'(a_pc_src), 1);
        check("a br taken target", 32'(a_target), 32'h0040);
        op(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0080, 3'd0, st, pv);
        check("a br not pc_src", 32'(a_pc_src), 0);
        check("a br not target", 32'(a_target), 32'h0080);
        check("a br not valid", 32'(a_valid), 1);
        op(0, 0, 0, 0, 0, 1, 16'h0055, 16'h0000, 16'h0000, 3'd3, st, pv);
        check("a alu reg_write", 32'(a_reg_write), 1);
        check("a alu result", 32'(a_alu), 32'h0055);
        check("a alu dst", 32'(a_dst), 3);
        op(0, 1, 1, 0, 0, 0, 16'h0002, 16'h00AA, 16'h0000, 3'd0, st, pv);
        check("a rdwr data", 32'(a_mem_data), 32'h00AA);
        op(0, 1, 0, 0, 0, 0, 16'h0002, 16'h0000, 16'h0000, 3'd0, st, pv);
        check("a ld2 data", 32'(a_mem_data), 32'h00AA);
        op(0, 0, 1, 0, 0, 0, 16'h0014, 16'hFFFF, 16'h0000, 3'd0, st, pv);
        check("a st20 data", 32'(a_mem_data), 32'hFFFF);
`ifdef MEM_STAGE_RANGE_CHECK_EN
        check("a st20 fault", 32'(a_fault), 1);
`endif
        op(0, 1, 0, 0, 0, 0, 16'h0014, 16'h0000, 16'h0000, 3'd0, st, pv);
        check("a ld20 data", 32'(a_mem_data), 0);
`ifdef MEM_STAGE_RANGE_CHECK_EN
        check("a ld20 fault", 32'(a_fault), 1);
`endif
        op(0, 1, 0, 0, 0, 0, 16'h0004, 16'h0000, 16'h0000, 3'd0, st, pv);
        check("a ld4 alias", 32'(a_mem_data), 32'h0101);
`ifdef MEM_STAGE_RANGE_CHECK_EN
        check("a ld4 fault", 32'(a_fault), 0);
`endif
        op(1, 0, 1, 0, 0, 0, 16'h0007, 16'hBEEF, 16'h0000, 3'd0, st, pv);
        check("b st7 stalls", 32'(st), 2);
        check("b st7 early valid", 32'(pv), 0);
        check("b st7 valid", 32'(b_valid), 1);
        check("b st7 data", 32'(b_mem_data), 32'hBEEF);
        op(1, 1, 0, 0, 0, 0, 16'h0007, 16'h0000, 16'h0000, 3'd0, st, pv);
        check("b ld7 stalls", 32'(st), 2);
        check("b ld7 early valid", 32'(pv), 0);
        check("b ld7 valid", 32'(b_valid), 1);
        check("b ld7 data", 32'(b_mem_data), 32'hBEEF);
        b_in = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h5555, 16'h0000, 3'd0};
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("b rst stall", 32'(b_stall), 0);
        check("b rst valid", 32'(b_valid), 0);
        check("b rst data", 32'(b_mem_data), 0);
        check("a rst alu", 32'(a_alu), 0);
        b_in = '0;
        @(negedge clock);
        reset_n = 1'b1;
        op(1, 1, 0, 0, 0, 0, 16'h0007, 16'h0000, 16'h0000, 3'd0, st, pv);
        check("b ld7 after rst", 32'(b_mem_data), 32'hBEEF);
        op(1, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0040, 3'd0, st, pv);
        check("b br stalls", 32'(st), 0);
        check("b br pc_src", 32'(b_pc_src), 1);
        check("b br target", 32'(b_target), 32'h0040);
        @(negedge clock);
        check("b pulse valid", 32'(b_valid), 0);
        check("b pulse pc_src", 32'(b_pc_src), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
- Parametrised successor to the processor's memory-access stage. Holds an internal word-addressed data memory with configurable access latency, and resolves the branch decision (PCSrc).
- Drives a registered MEM/WB pipeline register with a valid bit and a stall back to EX.
- Sits between the EX and WB stages of the 16-bit pipeline. Generalised in data width, depth and latency; adds a valid/stall handshake and reset.

Parameters:
- DATA_W, 16, width of ALU result, store data, load data and branch target
- ADDR_W, 8, word-address bits taken from alu_result[ADDR_W-1:0]
- DEPTH, 256, number of memory words (DEPTH <= 2**ADDR_W)
- REG_W, 3, destination register index width
- LATENCY, 1, memory access cycles (>= 1); 1 = single-cycle, no stall

Ports:
- clock  input  1  stage clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  EX presents a valid instruction
- mem_read  input  1  load
- mem_write  input  1  store
- branch  input  1  instruction is a conditional branch
- zero  input  1  ALU zero flag
- reg_write  input  1  instruction writes the register file
- alu_result  input  DATA_W  memory address / ALU result
- write_data  input  DATA_W  store data
- reg_dst  input  REG_W  destination register
- branch_target  input  DATA_W  shifted PC target
- stall  output  1  EX must hold all inputs stable this cycle
- out_valid  output  1  MEM/WB register holds a completed instruction
- out_mem_data  output  DATA_W  load data
- out_alu_result  output  DATA_W  passed-through ALU result
- out_reg_dst  output  REG_W  passed-through destination
- out_reg_write  output  1  passed-through write enable, qualified by out_valid
- pc_src  output  1  take branch
- out_branch_target  output  DATA_W  registered branch target

Behaviour:
- Reset (reset_n low, async): all outputs 0; FSM to IDLE; counter 0. Memory contents are not cleared.
- A reset during BUSY aborts the access. A pending store is not committed.
- FSM states:
  - IDLE: accepting.
  - BUSY: memory op in flight; counter cnt.
- Mem op = in_valid & (mem_read | mem_write).
- IDLE with in_valid and no mem op, or with LATENCY == 1:
  - Instruction completes at this edge; out_valid <= 1 next cycle; stall = 0.
  - Latency is one cycle for everything when LATENCY == 1.
- IDLE with a mem op and LATENCY > 1:
  - stall = 1 combinationally.
  - cnt <= LATENCY-1; go to BUSY.
- BUSY:
  - stall = (cnt > 1); cnt decrements each edge.
  - When cnt == 1, stall = 0 and the access commits at that edge. out_valid <= 1; FSM returns to IDLE.
- Timing: an instruction first presented in cycle t has out_valid high in cycle t+LATENCY. Total stall cycles = LATENCY-1.
- EX holds all inputs stable while stall = 1. The stage samples address/data only at the commit edge.
- out_valid is a one-cycle pulse per completed instruction. It is 0 in cycles with no completion (bubble); payload outputs then hold their last values.
- Store: mem[addr] <= write_data at the commit edge; out_mem_data <= write_data.
- Load: out_mem_data <= mem[addr] (pre-write contents).
- mem_read & mem_write together: treated as a store (write priority).
- Address addr = alu_result[ADDR_W-1:0]. If addr >= DEPTH: load returns 0, store is ignored.
- pc_src <= in_valid & branch & zero at completion; otherwise 0. out_branch_target registered alongside.
- out_alu_result, out_reg_dst registered at completion. out_reg_write <= reg_write at completion, else 0.
- Back-to-back mem ops with LATENCY > 1: the next op is accepted in the cycle after the commit (IDLE), with no extra bubble.

Optional Feature:
- Macro MEM_STAGE_RANGE_CHECK_EN.
- Defined: adds output out_fault (1 bit, reset 0). It is registered with out_valid and set when a completed mem op had addr >= DEPTH.
- Undefined: no out_fault port. Out-of-range behaviour is unchanged (load 0, store dropped).

Decomposition:
- Package mem_stage_pkg: FSM state typedef (IDLE, BUSY); default width constants DATA_W_DEF=16, REG_W_DEF=3.
- One sub-module: mem_stage_ram (DEPTH x DATA_W array, synchronous write, read port, out-of-range gating). The FSM, counter and MEM/WB register stay in the top module.

Test Plan:
- Reset: LATENCY=3. Drive a store, then pull reset_n low mid-BUSY → stall=0, out_valid=0, all outputs 0 immediately; a later load of that address returns the prior value.
- Single-cycle: LATENCY=1. Store 0x1234 at addr 5, then load addr 5 → out_valid in cycles t+1 and t+2, stall never high, second out_mem_data=0x1234.
- Multi-cycle: LATENCY=3. Load addr 7 (holding 0xBEEF) at cycle t → stall=1 in t, t+1; stall=0 in t+2; out_valid=1 and out_mem_data=0xBEEF in t+3.
- Branch: in_valid, branch=1, zero=1, branch_target=0x0040 → next cycle pc_src=1, out_branch_target=0x0040. With zero=0 → pc_src=0.
- Read+write together: mem_read=mem_write=1, addr 2, data 0x00AA → treated as a store; out_mem_data=0x00AA; subsequent load addr 2 returns 0x00AA.
- Out of range: DEPTH=16, store 0xFFFF to addr 20, then load addr 20 → load returns 0; out_fault=1 on both when MEM_STAGE_RANGE_CHECK_EN is defined.
